// File: rtl/seq_detect_stream_ctrl_pkg.sv
// Shared definitions for the serial-pattern-detector sequencer:
// one-hot state bit positions and the state encoding itself.
package seq_ctrl_pkg;

  localparam int STATE_W = 5;

  localparam int S_IDLE  = 0;
  localparam int S_CLEAR = 1;
  localparam int S_SHIFT = 2;
  localparam int S_DRAIN = 3;
  localparam int S_DONE  = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 5'b00001,
    ST_CLEAR = 5'b00010,
    ST_SHIFT = 5'b00100,
    ST_DRAIN = 5'b01000,
    ST_DONE  = 5'b10000
  } state_t;

endpackage

// File: rtl/seq_detect_stream_ctrl_piso_shift.sv
// Parallel-in serial-out shift register: parallel load, shift left,
// MSB presented on msb. Load wins over shift.
module piso_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic bit_reg;
      logic shift_in;

      // Bit 0 fills with zero; every other bit takes its lower neighbour.
      if (gi == 0) begin : g_lsb
        assign shift_in = 1'b0;
      end else begin : g_upper
        assign shift_in = g_bit[gi-1].bit_reg;
      end

      // One storage flop per bit: clear, load, or shift.
      always_ff @(posedge clk) begin
        if (!reset) begin
          bit_reg <= 1'b0;
        end else if (load) begin
          bit_reg <= din[gi];
        end else if (shift) begin
          bit_reg <= shift_in;
        end
      end
    end
  endgenerate

  assign msb = g_bit[WIDTH-1].bit_reg;

endmodule

// File: rtl/seq_detect_stream_ctrl.sv
// Sequencer for the serial pattern detector: accepts a word, clears the
// detector, streams the word MSB-first on det_w, counts z pulses and
// reports the count with a one-cycle done pulse.
module seq_detect_stream_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               in_ready,
  output logic               det_reset_n,
  output logic               det_w,
  input  logic               det_z,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   match_count,
  output logic [STATE_W-1:0] state_dbg
);

  localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           state_reg;
  logic [CNT_W-1:0] idx_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] match_count_reg;
  logic             done_reg;
  logic             accept;
  logic             sh_msb;

  assign accept = state_reg[S_IDLE] & in_valid;

  // Running count of z pulses seen while streaming or draining; saturates
  // so a misbehaving detector can never wrap the result.
  always_comb begin
    cnt_next = cnt_reg;
    if ((state_reg[S_SHIFT] | state_reg[S_DRAIN]) && det_z && (cnt_reg != CNT_MAX)) begin
      cnt_next = cnt_reg + ONE;
    end
  end

  piso_shift #(.WIDTH(WIDTH)) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (state_reg[S_SHIFT]),
    .din   (in_data),
    .msb   (sh_msb)
  );

  // Controller FSM with bit index, running count and registered result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= ST_IDLE;
      idx_reg         <= '0;
      cnt_reg         <= '0;
      match_count_reg <= '0;
      done_reg        <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            idx_reg   <= '0;
            cnt_reg   <= '0;
            state_reg <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          state_reg <= ST_SHIFT;
        end
        ST_SHIFT: begin
          cnt_reg <= cnt_next;
          idx_reg <= idx_reg + ONE;
          if (idx_reg == IDX_LAST) begin
            state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The last pair's z is visible now; fold it into the result.
          cnt_reg         <= cnt_next;
          match_count_reg <= cnt_next;
          done_reg        <= 1'b1;
          state_reg       <= ST_DONE;
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = state_reg[S_IDLE];
  assign busy        = ~state_reg[S_IDLE];
  assign done        = done_reg;
  assign match_count = match_count_reg;
  assign state_dbg   = state_reg;
  assign det_w       = state_reg[S_SHIFT] & sh_msb;
  assign det_reset_n = reset & ~state_reg[S_CLEAR];

endmodule

// File: tb/tb_seq_detect_stream_ctrl.sv
// Bench for seq_detect_stream_ctrl with a behavioural model of the
// "last two bits equal" detector and a scoreboard of expected counts.
module tb_seq_detect_stream_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             det_reset_n;
  logic             det_w;
  logic             det_z;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] match_count;
  logic [4:0]       state_dbg;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int clr_lows = 0;
  logic prev_done = 1'b0;

  typedef struct {
    logic [WIDTH-1:0] word;
    int               cnt;
    int               acc_cyc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  seq_detect_stream_ctrl #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .det_reset_n (det_reset_n),
    .det_w       (det_w),
    .det_z       (det_z),
    .busy        (busy),
    .done        (done),
    .match_count (match_count),
    .state_dbg   (state_dbg)
  );

  // Detector model: Moore z = last two bits received were equal.
  logic m_have, m_prev, m_z;
  always @(posedge clk) begin
    if (!det_reset_n) begin
      m_have <= 1'b0;
      m_prev <= 1'b0;
      m_z    <= 1'b0;
    end else begin
      m_z    <= m_have && (det_w == m_prev);
      m_prev <= det_w;
      m_have <= 1'b1;
    end
  end
  assign det_z = m_z;

  always @(posedge clk) cyc++;

  function automatic int pairs(input logic [WIDTH-1:0] w);
    int n = 0;
    for (int i = 0; i < WIDTH - 1; i++) if (w[i] == w[i+1]) n++;
    return n;
  endfunction

  // Scoreboard: push on accept, pop and compare on done.
  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
      clr_lows = 0;
    end else begin
      if (!det_reset_n) clr_lows++;
      if (in_valid && in_ready) begin
        exp_t e;
        e.word = in_data;
        e.cnt = pairs(in_data);
        e.acc_cyc = cyc;
        sb.push_back(e);
      end
      if (done) begin
        done_cnt++;
        n_vec++;
        if (prev_done) begin
          n_err++;
          $display("FAIL done_width: done high %0d cycles, required 1", 2);
        end
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: match_count=%0d with no word pending", match_count);
        end else begin
          exp_t e;
          e = sb.pop_front();
          n_vec += 3;
          if (match_count !== CNT_W'(e.cnt)) begin
            n_err++;
            $display("FAIL match_count word=%h: got %0d, expected %0d", e.word, match_count, e.cnt);
          end
          if (cyc - e.acc_cyc != WIDTH + 3) begin
            n_err++;
            $display("FAIL latency word=%h: got %0d cycles, expected %0d", e.word, cyc - e.acc_cyc, WIDTH + 3);
          end
          if (clr_lows != 1) begin
            n_err++;
            $display("FAIL det_clear word=%h: det_reset_n low %0d cycles, expected 1", e.word, clr_lows);
          end
          $display("word %h -> match_count %0d (expected %0d)", e.word, match_count, e.cnt);
        end
        clr_lows = 0;
      end
    end
    prev_done = done;
  end

  // Present a word and hold in_valid until it is accepted.
  task automatic send_word(input logic [WIDTH-1:0] w);
    bit ok = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL accept_timeout word=%h: in_ready=%b, required 1", w, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s done_timeout: done=%b, required 1", tag, done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (det_reset_n !== 1'b0) begin
        n_err++;
        $display("FAIL reset_det_clear cycle %0d: det_reset_n=%b, required 0", i, det_reset_n);
      end
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    n_vec += 6;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b, required 0", done); end
    if (match_count !== '0) begin n_err++; $display("FAIL reset_match_count: got %0d, required 0", match_count); end
    if (state_dbg !== 5'b00001) begin n_err++; $display("FAIL reset_state: got %b, required 00001", state_dbg); end
    if (det_w !== 1'b0) begin n_err++; $display("FAIL reset_det_w: got %b, required 0", det_w); end
    $display("reset: in_ready=%b busy=%b state=%b", in_ready, busy, state_dbg);
  endtask

  // Stream one word, checking the serial bit and busy on each SHIFT cycle.
  task automatic test_stream(input logic [WIDTH-1:0] w);
    send_word(w);
    @(negedge clk);  // CLEAR
    n_vec++;
    if (det_reset_n !== 1'b0 || det_w !== 1'b0) begin
      n_err++;
      $display("FAIL clear_cycle word=%h: det_reset_n=%b det_w=%b, required 0 0", w, det_reset_n, det_w);
    end
    for (int i = 0; i < WIDTH; i++) begin
      logic [WIDTH-1:0] wv;
      wv = w;
      @(negedge clk);
      n_vec++;
      if (det_w !== wv[WIDTH-1-i] || busy !== 1'b1) begin
        n_err++;
        $display("FAIL det_w word=%h bit %0d: det_w=%b busy=%b, required %b 1", w, i, det_w, busy, wv[WIDTH-1-i]);
      end
    end
    wait_done($sformatf("stream_%h", w));
  endtask

  task automatic test_abort();
    int d0;
    send_word(8'h00);
    @(negedge clk);                       // CLEAR
    for (int i = 0; i < 3; i++) @(negedge clk);  // SHIFT 1..3
    @(posedge clk); #1;                   // now in SHIFT 4
    reset = 1'b0;
    d0 = done_cnt;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 16; i++) @(negedge clk);
    n_vec += 3;
    if (done_cnt != d0) begin n_err++; $display("FAIL abort_done: got %0d pulses, required 0", done_cnt - d0); end
    if (match_count !== '0) begin n_err++; $display("FAIL abort_match_count: got %0d, required 0", match_count); end
    if (state_dbg !== 5'b00001) begin n_err++; $display("FAIL abort_state: got %b, required 00001", state_dbg); end
    $display("abort: match_count=%0d state=%b", match_count, state_dbg);
    test_stream(8'h00);
  endtask

  task automatic test_back_to_back();
    int last = -1;
    int accepts = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk); #1;
      in_data = WIDTH'($urandom);
      @(negedge clk);
      if (in_valid && in_ready) begin
        if (last >= 0) begin
          n_vec++;
          if (cyc - last != WIDTH + 4) begin
            n_err++;
            $display("FAIL b2b_spacing: got %0d cycles, required %0d", cyc - last, WIDTH + 4);
          end
        end
        $display("b2b accept word %h at cycle %0d", in_data, cyc);
        last = cyc;
        accepts++;
      end
      n_vec++;
      if (in_ready !== ~busy) begin
        n_err++;
        $display("FAIL b2b_ready_busy: in_ready=%b busy=%b, required complementary", in_ready, busy);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) @(negedge clk);
    n_vec += 2;
    if (accepts < 3) begin n_err++; $display("FAIL b2b_accepts: got %0d, required >= 3", accepts); end
    if (sb.size() != 0) begin n_err++; $display("FAIL b2b_pending: got %0d words outstanding, required 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_stream(8'hFF);
    test_stream(8'hAA);
    test_stream(8'hCC);
    test_stream(8'hF0);
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
